// File: rtl/spi_flash_arbiter_pkg.sv
// Shared definitions for the SPI flash arbiter: FSM encodings, SPI idle
// levels and the CPU-starvation counter width.
package spi_flash_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CTRL_OWN = 2'd1,
    ST_WR_OWN   = 2'd2,
    ST_GUARD    = 2'd3
  } arb_state_t;

  localparam logic CS_IDLE   = 1'b1;
  localparam logic CLK_IDLE  = 1'b0;
  localparam logic MOSI_IDLE = 1'b0;

  localparam int TIMEOUT_W = 16;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit; flops reset to
// RESET_VAL so the downstream logic sees a defined "inactive" level.
module bit_synchronizer #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= {STAGES{RESET_VAL}};
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/spi_flash_arbiter.sv
// Sequential arbiter sharing one SPI flash between the ROM read controller
// and the FT2232 writer; ownership changes only with the owner's CS high.
module spi_flash_arbiter
  import spi_flash_arbiter_pkg::*;
#(
  parameter int GUARD_CYCLES   = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_ctrl_req,
  input  logic       i_ctrl_spi_clk,
  input  logic       i_ctrl_spi_mosi,
  input  logic       i_ctrl_spi_cs,
  input  logic       i_FT_CS,
  input  logic       i_wr_spi_clk,
  input  logic       i_wr_spi_mosi,
  input  logic       i_wr_spi_cs,
  output logic       o_SPI_CLK,
  output logic       o_SPI_MOSI,
  output logic       o_SPI_CS,
  output logic       o_ctrl_grant,
  output logic       o_wr_grant,
  output logic       o_ctrl_wait,
  output logic       o_timeout,
  output logic [1:0] o_state
);

  localparam int GUARD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GUARD_W-1:0] GUARD_LAST =
    GUARD_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_MAX = TIMEOUT_W'(TIMEOUT_CYCLES);

  arb_state_t           state_reg, state_next;
  logic [GUARD_W-1:0]   guard_cnt_reg;
  logic [TIMEOUT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic                 ctrl_grant_reg, wr_grant_reg, timeout_reg;
  logic                 ft_cs_s, wr_req_s;

  bit_synchronizer #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_ft_cs_sync (
    .clk  (clk),
    .rst_n(reset),
    .d    (i_FT_CS),
    .q    (ft_cs_s)
  );

  assign wr_req_s = ~ft_cs_s;

  // Owners release only once their request is gone AND their CS is high.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (wr_req_s)        state_next = ST_WR_OWN;
        else if (i_ctrl_req) state_next = ST_CTRL_OWN;
      end
      ST_CTRL_OWN: begin
        if (!i_ctrl_req && i_ctrl_spi_cs)
          state_next = (GUARD_CYCLES == 0) ? ST_IDLE : ST_GUARD;
      end
      ST_WR_OWN: begin
        if (!wr_req_s && i_wr_spi_cs)
          state_next = (GUARD_CYCLES == 0) ? ST_IDLE : ST_GUARD;
      end
      ST_GUARD: begin
        if (guard_cnt_reg == GUARD_LAST) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign o_ctrl_wait = i_ctrl_req && (state_reg != ST_CTRL_OWN);

  always_comb begin
    wait_cnt_next = '0;
    if (o_ctrl_wait)
      wait_cnt_next = (wait_cnt_reg == TIMEOUT_MAX) ? wait_cnt_reg : wait_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      guard_cnt_reg  <= '0;
      ctrl_grant_reg <= 1'b0;
      wr_grant_reg   <= 1'b0;
      wait_cnt_reg   <= '0;
      timeout_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ctrl_grant_reg <= (state_next == ST_CTRL_OWN);
      wr_grant_reg   <= (state_next == ST_WR_OWN);
      if (state_reg == ST_GUARD && state_next == ST_GUARD)
        guard_cnt_reg <= guard_cnt_reg + 1'b1;
      else
        guard_cnt_reg <= '0;
      wait_cnt_reg <= wait_cnt_next;
      if (wait_cnt_next == TIMEOUT_MAX)
        timeout_reg <= 1'b1;
    end
  end

  // SPI lines are muxed straight through so the writer's SCK is never resampled.
  always_comb begin
    o_SPI_CS   = CS_IDLE;
    o_SPI_CLK  = CLK_IDLE;
    o_SPI_MOSI = MOSI_IDLE;
    case (state_reg)
      ST_CTRL_OWN: begin
        o_SPI_CS   = i_ctrl_spi_cs;
        o_SPI_CLK  = i_ctrl_spi_clk;
        o_SPI_MOSI = i_ctrl_spi_mosi;
      end
      ST_WR_OWN: begin
        o_SPI_CS   = i_wr_spi_cs;
        o_SPI_CLK  = i_wr_spi_clk;
        o_SPI_MOSI = i_wr_spi_mosi;
      end
      default: ;
    endcase
  end

  assign o_ctrl_grant = ctrl_grant_reg;
  assign o_wr_grant   = wr_grant_reg;
  assign o_timeout    = timeout_reg;
  assign o_state      = state_reg;

endmodule
